// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display arbiter:
// hex-to-segment table, blank patterns and the ownership FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segments, bit 6 = a ... bit 0 = g
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle of the display arbiter plus the display pins and a
// debug view of the ownership FSM state.
interface seg_display_arbiter_if #(
    parameter int REQ_N = 4
);
    // Handshake: req[i] is a level request held for as long as requester i
    // wants the display; grant is its one-hot acknowledge, changing only in
    // the cycle after a frame boundary. While granted (and during the hold
    // window even after req drops) the owner's digits_in/blank_in are shown
    // live, one cycle after they are presented.
    logic [REQ_N-1:0]    req;
    logic [16*REQ_N-1:0] digits_in;
    logic [4*REQ_N-1:0]  blank_in;
    logic [REQ_N-1:0]    grant;
    logic [2:0]          owner;
    logic                busy;
    logic [3:0]          an_n;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [1:0]          state;

    modport master (
        output req, digits_in, blank_in,
        input  grant, owner, busy, an_n, seg_n, dp_n, state
    );

    modport slave (
        input  req, digits_in, blank_in,
        output grant, owner, busy, an_n, seg_n, dp_n, state
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit multiplexed display with minimum
// hold and a blank frame between owners. Optional SEG_DIM_EN adds bright[1:0].
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int REQ_N       = 4,
    parameter int SCAN_DIV    = 65536,
    parameter int HOLD_FRAMES = 16
) (
    input logic clk,
    input logic rst,
`ifdef SEG_DIM_EN
    input logic [1:0] bright,
`endif
    seg_display_arbiter_if.slave bus
);

    localparam int OW = $clog2(REQ_N);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig_idx;
    logic          slot_tick;
    logic          frame_tick;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          rr_found;
    logic [OW-1:0] rr_pick;
    logic [OW-1:0] cand;
    logic          req_others;

    logic [3:0]    nib [REQ_N][4];
    logic          blk [REQ_N][4];
    logic [3:0]    nib_sel;
    logic          blank_sel;
    logic          duty_on;
    logic [6:0]    seg_dec;
    logic [3:0]    an_d, an_q;
    logic [6:0]    seg_d, seg_q;

    assign slot_tick  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_tick = slot_tick && (dig_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= 2'd0;
        end else begin
            scan_cnt <= slot_tick ? '0 : scan_cnt + SW'(1);
            if (slot_tick)
                dig_idx <= dig_idx + 2'd1;
        end
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        cand     = '0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand = OW'((int'(last_q) + i) % REQ_N);
            if (!rr_found && bus.req[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    assign req_others = |(bus.req & ~(REQ_N'(1) << owner_q));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (frame_tick) begin
            case (state_q)
                IDLE, GAP: begin
                    if (rr_found) begin
                        state_d = OWN;
                        owner_d = rr_pick;
                        last_d  = rr_pick;
                        hold_d  = HW'(HOLD_FRAMES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                OWN: begin
                    // No preemption: an owner past its hold leaves only by dropping req.
                    if (hold_q != '0)
                        hold_d = hold_q - HW'(1);
                    else if (!bus.req[owner_q])
                        state_d = req_others ? GAP : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(REQ_N - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        for (int r = 0; r < REQ_N; r++) begin
            for (int d = 0; d < 4; d++) begin
                nib[r][d] = bus.digits_in[16*r + 4*d +: 4];
                blk[r][d] = bus.blank_in[4*r + d];
            end
        end
    end

    assign nib_sel   = nib[owner_q][dig_idx];
    assign blank_sel = blk[owner_q][dig_idx];

    seg_hex_decoder u_dec (
        .nibble (nib_sel),
        .seg_n  (seg_dec)
    );

`ifdef SEG_DIM_EN
    assign duty_on = int'(scan_cnt) < (((int'(bright) + 1) * SCAN_DIV) / 4);
`else
    assign duty_on = 1'b1;
`endif

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_q == OWN) begin
            seg_d = seg_dec;
            if (!blank_sel && duty_on)
                an_d = ~(4'b0001 << dig_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.grant = (state_q == OWN) ? (REQ_N'(1) << owner_q) : '0;
    assign bus.owner = 3'(owner_q);
    assign bus.busy  = (state_q == OWN);
    assign bus.an_n  = an_q;
    assign bus.seg_n = seg_q;
    assign bus.dp_n  = 1'b1;
    assign bus.state = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, HOLD_FRAMES=2, REQ_N=4
// (16 clocks per frame; frame boundaries fall on cycles 16, 32, 48 ... after reset).
module tb_seg_display_arbiter;
  import seg_pkg::*;

  localparam int REQ_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SEG_DIM_EN
  logic [1:0] bright = 2'd3;
`endif

  seg_display_arbiter_if #(.REQ_N(REQ_N)) bus ();

  seg_display_arbiter #(
    .REQ_N       (REQ_N),
    .SCAN_DIV    (4),
    .HOLD_FRAMES (2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
`ifdef SEG_DIM_EN
    .bright (bright),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc;
  int n_checks;
  int n_pass;
  logic [10:0] exp_q[$];
  logic [10:0] e;
  logic [15:0] d0;

  logic [6:0] hex_seg [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.req       = '0;
    bus.digits_in = '0;
    bus.blank_in  = '0;

    // Reset values and three idle frames
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_owner", 32'(bus.owner), 32'(0));
    check("rst_busy",  32'(bus.busy),  32'(0));
    check("rst_an",    32'(bus.an_n),  32'h0000_000F);
    check("rst_seg",   32'(bus.seg_n), 32'h0000_007F);
    check("rst_dp",    32'(bus.dp_n),  32'(1));
    check("rst_state", 32'(bus.state), 32'(IDLE));
    for (int c = 1; c <= 48; c++) begin
      tick();
      check("idle_dark", 32'({bus.busy, bus.grant, bus.an_n, bus.seg_n}),
            32'({1'b0, 4'h0, 4'hF, 7'h7F}));
    end

    // Single requester: grant at first frame boundary, then one scanned frame
    bus.req       = 4'b0001;
    bus.digits_in = 64'hFFFF_FFFF_FFFF_0123;
    d0            = 16'h0123;
    do_reset();
    run_to(15);
    check("pre_grant", 32'(bus.grant), 32'(0));
    run_to(16);
    check("grant0",     32'(bus.grant), 32'(4'b0001));
    check("busy0",      32'(bus.busy),  32'(1));
    check("owner0",     32'(bus.owner), 32'(0));
    check("first_dark", 32'(bus.an_n),  32'h0000_000F);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({4'(~(4'b0001 << s)), hex_seg[d0[4*s +: 4]]});
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check("own_scan", 32'({bus.an_n, bus.seg_n}), 32'(e));
    end
    run_to(48);
    bus.digits_in[15:0] = 16'hABCD;
    tick();
    check("live_digit", 32'({bus.an_n, bus.seg_n}), 32'({4'b1110, 7'b1000010}));

    // Tie from reset, owner drops inside hold window, gap frame, then req2
    bus.req       = 4'b0101;
    bus.digits_in = 64'h0000_0000_0000_4567;
    do_reset();
    run_to(16);
    check("tie_req0", 32'(bus.grant), 32'(4'b0001));
    run_to(32);
    bus.req = 4'b0100;
    run_to(41);
    check("hold_keep", 32'(bus.grant), 32'(4'b0001));
    check("hold_live", 32'({bus.an_n, bus.seg_n}), 32'({4'b1011, 7'b0100100}));
    run_to(47);
    check("hold_end", 32'(bus.grant), 32'(4'b0001));
    run_to(48);
    check("gap_grant", 32'(bus.grant), 32'(0));
    check("gap_busy",  32'(bus.busy),  32'(0));
    check("gap_state", 32'(bus.state), 32'(GAP));
    run_to(56);
    check("gap_dark", 32'({bus.an_n, bus.seg_n}), 32'({4'hF, 7'h7F}));
    run_to(63);
    check("gap_last", 32'(bus.grant), 32'(0));
    run_to(64);
    check("grant2", 32'(bus.grant), 32'(4'b0100));
    check("owner2", 32'(bus.owner), 32'(2));

    // No preemption of a holding owner; rotation to req3 after it leaves
    bus.req = 4'b1010;
    do_reset();
    run_to(16);
    check("grant1", 32'(bus.grant), 32'(4'b0010));
    run_to(96);
    check("no_preempt", 32'(bus.grant), 32'(4'b0010));
    run_to(100);
    bus.req = 4'b1000;
    run_to(111);
    check("still1", 32'(bus.grant), 32'(4'b0010));
    run_to(112);
    check("gap2_grant", 32'(bus.grant), 32'(0));
    check("gap2_state", 32'(bus.state), 32'(GAP));
    run_to(127);
    check("gap2_last", 32'(bus.grant), 32'(0));
    run_to(128);
    check("grant3", 32'(bus.grant), 32'(4'b1000));
    check("owner3", 32'(bus.owner), 32'(3));

    // Per-digit blanking of the owner
    bus.req       = 4'b0001;
    bus.digits_in = 64'h0000_0000_0000_89AB;
    bus.blank_in  = 16'h000C;
    do_reset();
    run_to(18);
    check("blank_s0", 32'({bus.an_n, bus.seg_n}), 32'({4'b1110, 7'b1100000}));
    run_to(22);
    check("blank_s1", 32'({bus.an_n, bus.seg_n}), 32'({4'b1101, 7'b0001000}));
    run_to(26);
    check("blank_s2", 32'(bus.an_n), 32'h0000_000F);
    run_to(30);
    check("blank_s3", 32'(bus.an_n), 32'h0000_000F);
    run_to(34);
    check("blank_wrap", 32'(bus.an_n), 32'(4'b1110));

    // Reset while owning goes dark at once; tie resolves to req0 again
    bus.req      = 4'b0101;
    bus.blank_in = '0;
    do_reset();
    run_to(20);
    check("mid_own", 32'(bus.grant), 32'(4'b0001));
    rst = 1'b1;
    tick();
    check("mrst_an",    32'(bus.an_n),  32'h0000_000F);
    check("mrst_seg",   32'(bus.seg_n), 32'h0000_007F);
    check("mrst_grant", 32'(bus.grant), 32'(0));
    check("mrst_busy",  32'(bus.busy),  32'(0));
    tick();
    rst = 1'b0;
    cyc = 0;
    run_to(15);
    check("mrst_wait", 32'(bus.grant), 32'(0));
    run_to(16);
    check("mrst_tie", 32'(bus.grant), 32'(4'b0001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
